ex_mem_stage_buf: RTL
=====================

# ex_mem_stage_buf

Parametrised EX→MEM pipeline stage buffer: a DEPTH-entry in-order queue between the execute and data-memory stages, with valid/ready handshakes on both sides. It replaces the fixed single-slot EX/DM register. It adds back-pressure from MEM, a full-pipeline flush, and a registered branch-redirect output captured from branch instructions leaving EX. Upstream is the EX stage; downstream are the data-memory stage and the hazard unit.

## Interface

Parameters:
- XLEN, 32, width of ALU result, store data and PC
- RD_W, 5, destination register index width
- DEPTH, 2, queue entries; power of two, ≥2

Ports:
- clk  in  1  stage clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  EX offers an instruction
- in_ready  out  1  buffer accepts this cycle
- in_alu_result  in  XLEN  ALU result / memory address
- in_store_data  in  XLEN  store write data
- in_rd  in  RD_W  destination register
- in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write  in  1 each  control bits
- in_branch  in  1  offered instruction is a taken branch
- in_pc  in  XLEN  branch target when in_branch=1
- flush_all  in  1  discard everything (exception/replay)
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM consumes head
- out_alu_result, out_store_data  out  XLEN  head payload
- out_rd  out  RD_W  head destination
- out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write  out  1 each  head control, forced 0 when out_valid=0
- redirect_valid  out  1  one-cycle pulse: fetch redirect
- redirect_pc  out  XLEN  redirect target, held until next redirect
- occupancy  out  $clog2(DEPTH+1)  entries held

## Operation

- push = in_valid & in_ready & ~in_branch & ~flush_all; pop = out_valid & out_ready.
- in_ready = (occupancy != DEPTH). It is decoded from the registered count only, with no combinational path from out_ready. When full, push is blocked even if a pop occurs in the same cycle.
- Branch capture: when in_valid & in_ready & in_branch & ~flush_all, no entry is written. redirect_pc ← in_pc and redirect_valid = 1 for exactly the next cycle. MEM never sees branch control bits, because a branch produces no memory or writeback side effect.
- flush_all has highest priority. Next cycle: occupancy = 0, pointers = 0, out_valid = 0, redirect_valid = 0. Push and branch capture in the flush cycle are dropped. A pop handshake in the flush cycle is still a completed transfer, since the entry was already presented.
- Ordering is strict FIFO. Head fields are stable while out_valid & ~out_ready.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. occupancy is +1 on push only, −1 on pop only, and unchanged on both or neither.
- Reset values: occupancy 0, pointers 0, out_valid 0, every out_* control 0, out_alu_result/out_store_data/out_rd 0, redirect_valid 0, redirect_pc 0, in_ready 1 after reset releases. Reset asserted mid-transfer empties the queue immediately and asynchronously.

## Timing

- Latency: push in cycle N → out_valid=1 with that payload in N+1, if the queue was empty.
- Throughput: one push and one pop per cycle when 0 < occupancy < DEPTH.
- Branch offered in cycle N → redirect_valid high in N+1 only. A second branch in N+1 → pulse again in N+2 with the new pc.
- out_* are driven from storage and the registered head pointer, with no input-to-output combinational path. in_ready depends only on registers.
- Reset deassertion is synchronised externally. The block only requires reset to be low for at least one clk edge.

## Structure

- Package pipe_pkg: typedef struct ex_mem_payload_t {alu_result, store_data, rd, mem_read, mem_write, mem_to_reg, reg_write}, plus localparams for XLEN/RD_W defaults.
- Sub-module sync_fifo (parametrised WIDTH, DEPTH; push/pop/flush, count, head data). The top level packs the payload and adds the branch/redirect logic and output gating.

## Test plan

- Reset low mid-stream with occupancy 2 → immediately out_valid=0, occupancy=0, all controls 0; after release in_ready=1.
- Push A (alu=0x10, rd=3, reg_write=1) with out_ready=1 → next cycle out_alu_result=0x10, out_rd=3, out_reg_write=1, then popped; occupancy returns 0.
- out_ready=0, push A,B (DEPTH=2) → in_ready=0, a third offer C is not accepted. Raise out_ready → A, B, C drain in order, one per cycle.
- Offer branch with in_pc=0x400 → no entry written, redirect_valid one cycle, redirect_pc=0x400, out_mem_write stays 0.
- Occupancy 2, assert flush_all together with in_valid for D and out_ready=1 → A counted consumed, next cycle occupancy=0, D absent.
- DEPTH=4, 20 random push/pop cycles crossing the wrap point → output sequence equals input sequence; occupancy never exceeds 4.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared EX->MEM pipeline types and default widths.
// Payload packing order is fixed here: {alu_result, store_data, rd, ctrl}.
package pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RD_W_DEF = 5;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] alu_result;
        logic [XLEN_DEF-1:0] store_data;
        logic [RD_W_DEF-1:0] rd;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                reg_write;
    } ex_mem_payload_t;

    function automatic int payload_w(input int xlen, input int rd_w);
        return 2 * xlen + rd_w + $bits(ex_mem_ctrl_t);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic in-order FIFO with flush; push lands at the head one cycle later.
// Latency 1; a push while full is dropped even if a pop occurs that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i & (count_q != CW'(DEPTH)) & ~flush_i;
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM stage queue with branch-redirect capture and full flush; latency 1.
// in_ready is decoded from the registered count only, so MEM stall never loops back combinationally.
module ex_mem_stage_buf
    import pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RD_W  = RD_W_DEF,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [XLEN-1:0]             in_alu_result,
    input  logic [XLEN-1:0]             in_store_data,
    input  logic [RD_W-1:0]             in_rd,
    input  logic                        in_mem_read,
    input  logic                        in_mem_write,
    input  logic                        in_mem_to_reg,
    input  logic                        in_reg_write,
    input  logic                        in_branch,
    input  logic [XLEN-1:0]             in_pc,
    input  logic                        flush_all,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_alu_result,
    output logic [XLEN-1:0]             out_store_data,
    output logic [RD_W-1:0]             out_rd,
    output logic                        out_mem_read,
    output logic                        out_mem_write,
    output logic                        out_mem_to_reg,
    output logic                        out_reg_write,
    output logic                        redirect_valid,
    output logic [XLEN-1:0]             redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int PLW = payload_w(XLEN, RD_W);
    localparam int OW  = $clog2(DEPTH+1);

    ex_mem_ctrl_t    in_ctrl, head_ctrl;
    logic [PLW-1:0]  wdata, rdata;
    logic [OW-1:0]   count;
    logic            accept, push, pop, br_take;
    logic            redir_vld_q, redir_vld_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    assign in_ready = (count != OW'(DEPTH));
    assign accept   = in_valid & in_ready & ~flush_all;
    // Branches never occupy a slot: MEM must not see their control bits.
    assign push     = accept & ~in_branch;
    assign br_take  = accept & in_branch;
    assign pop      = out_valid & out_ready;

    assign in_ctrl = '{mem_read:   in_mem_read,
                       mem_write:  in_mem_write,
                       mem_to_reg: in_mem_to_reg,
                       reg_write:  in_reg_write};
    assign wdata   = {in_alu_result, in_store_data, in_rd, in_ctrl};

    sync_fifo #(
        .WIDTH (PLW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_all),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .count_o (count)
    );

    assign {out_alu_result, out_store_data, out_rd, head_ctrl} = rdata;
    assign out_valid      = (count != '0);
    assign out_mem_read   = out_valid & head_ctrl.mem_read;
    assign out_mem_write  = out_valid & head_ctrl.mem_write;
    assign out_mem_to_reg = out_valid & head_ctrl.mem_to_reg;
    assign out_reg_write  = out_valid & head_ctrl.reg_write;
    assign occupancy      = count;

    always_comb begin
        redir_vld_d = br_take;
        redir_pc_d  = br_take ? in_pc : redir_pc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    assign redirect_valid = redir_vld_q;
    assign redirect_pc    = redir_pc_q;

endmodule
